// File: rtl/rr_grant_ctrl_if.sv
// Handshake bundle between requesters and the round-robin grant controller.
// master = requester side, slave = arbiter side.
interface rr_grant_ctrl_if #(
    parameter int N    = 8,
    parameter int LOGN = 3
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [LOGN-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: holds a registered one-hot grant until release, then rotates priority.
// Optional forced release after MAXHOLD cycles is enabled by defining RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl #(
    parameter int N       = 8,
    parameter int LOGN    = 3,
    parameter int MAXHOLD = 16
) (
    input  logic           clk,
    input  logic           reset,
    rr_grant_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    if (N < 2 || N > 16 || (1 << LOGN) < N || MAXHOLD < 1 || MAXHOLD > 255) begin : g_bad_params
        $error("rr_grant_ctrl: illegal parameter combination");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [LOGN-1:0] idx_q, idx_d;
    logic [LOGN-1:0] ptr_q, ptr_d;

    logic [N-1:0]    arb_req;
    logic [LOGN-1:0] arb_ptr;
    logic            arb_found;
    logic [LOGN-1:0] arb_idx;
    logic [LOGN-1:0] ptr_next;
    logic            owner_req;
    logic            force_rel;
    logic            release_now;

`ifdef RR_GRANT_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign force_rel = (state_q == OWN) && (hold_q == 8'(MAXHOLD - 1)) && !bus.done && owner_req;
`else
    assign force_rel = 1'b0;
`endif

    assign owner_req   = bus.req[idx_q];
    assign ptr_next    = (idx_q == LOGN'(N - 1)) ? '0 : idx_q + LOGN'(1);
    assign release_now = (state_q == OWN) && (bus.done || !owner_req || force_rel);

    // On a release the arbiter already sees the rotated pointer, so the outgoing owner ranks last.
    always_comb begin
        arb_ptr = ptr_q;
        arb_req = bus.req;
        if (state_q == OWN) begin
            arb_ptr = ptr_next;
            if (bus.done || force_rel) begin
                arb_req = bus.req & ~gnt_q;
            end
        end
    end

    always_comb begin
        logic [LOGN:0] pos;
        arb_found = 1'b0;
        arb_idx   = '0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, arb_ptr} + (LOGN + 1)'(k);
            if (pos >= (LOGN + 1)'(N)) begin
                pos = pos - (LOGN + 1)'(N);
            end
            if (!arb_found && arb_req[pos[LOGN-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = pos[LOGN-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef RR_GRANT_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = OWN;
                    gnt_d   = {{(N - 1){1'b0}}, 1'b1} << arb_idx;
                    idx_d   = arb_idx;
`ifdef RR_GRANT_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            OWN: begin
                if (release_now) begin
                    ptr_d = ptr_next;
`ifdef RR_GRANT_TIMEOUT_EN
                    timeout_d = force_rel;
                    hold_d    = '0;
`endif
                    if (arb_found) begin
                        gnt_d = {{(N - 1){1'b0}}, 1'b1} << arb_idx;
                        idx_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
`ifdef RR_GRANT_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
        endcase
    end

    always_comb begin
        bus.gnt       = gnt_q;
        bus.gnt_idx   = idx_q;
        bus.gnt_valid = |gnt_q;
`ifdef RR_GRANT_TIMEOUT_EN
        bus.timeout   = timeout_q;
`else
        bus.timeout   = 1'b0;
`endif
    end
endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Sequential round-robin arbiter/controller that shares one datapath resource (e.g. a shared encoder/comparator unit) among N requesters.
- Registers a one-hot grant plus binary grant index, holds the grant until the owner releases it, then rotates priority so the last owner becomes lowest priority.
- Sits between requester blocks and the shared resource's operand mux; gnt drives the mux one-hot select directly.

Parameters:
- N, 8, number of requesters (2..16)
- LOGN, 3, width of gnt_idx; must satisfy 2^LOGN >= N
- MAXHOLD, 16, maximum cycles a grant may be held (used only with the optional feature); 1..255

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  N  request per requester, level-sensitive
- done  input  1  current owner releases the resource this cycle
- gnt  output  N  registered one-hot grant; all zero when idle
- gnt_idx  output  LOGN  binary index of the owner; 0 when idle
- gnt_valid  output  1  registered, equals |gnt
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (reset=0, asynchronous): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, priority pointer ptr=0, hold counter=0.
- States: IDLE (no owner), OWN (one owner holds gnt).
- Arbitration function: among req bits, select the first set bit searching upward from index ptr, wrapping N-1 -> 0. Pure combinational; result is registered.
- IDLE: if req != 0, next edge loads gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, state=OWN. Latency: request asserted in cycle t -> gnt visible in cycle t+1. If req == 0, stay in IDLE.
- OWN, release condition = done==1 OR req[gnt_idx]==0 OR forced timeout.
- On release at edge: ptr <= (gnt_idx+1) mod N. The next owner is chosen in the same cycle using the updated priority (owner lowest) from req with the owner's own bit masked if done or timeout. The winner loads on that same edge (back-to-back handoff, no bubble). If no other requester exists, go to IDLE with gnt=0.
- The owner still requesting after done, with no other requesters: gnt goes 0 for one cycle (IDLE), then is re-granted.
- OWN, no release: gnt, gnt_idx, ptr unchanged. Changes on other req bits are ignored (no preemption).
- done while in IDLE is ignored.
- gnt is always one-hot or zero; gnt_idx always matches gnt.
- Requester indices >= N never exist; wrap uses mod N, not mod 2^LOGN.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). After deassertion, arbitration restarts from ptr=0.

Optional Feature:
- Macro RR_GRANT_TIMEOUT_EN.
- Defined: an 8-bit hold counter clears on each new grant and increments each cycle in OWN. When the count reaches MAXHOLD-1 without release, the next edge force-releases. timeout pulses high for exactly that one cycle, coincident with the gnt change. The owner's bit is masked for the re-arbitration and ptr advances as for a normal release.
- Not defined: no counter is instantiated, timeout is tied 0, and grants are held indefinitely until done or the owner's req drops.

Test Plan (N=8, MAXHOLD=4):
- Reset, then req=8'b0000_0100 -> next cycle gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1; hold 5 cycles (no done, macro off) -> gnt stays unchanged.
- req=8'b1000_0011 from ptr=0, pulse done each grant -> successive owners 0, 1, 7, 0, with no idle cycle between handoffs.
- Owner 3 holding, req[5] rises and falls mid-grant -> gnt stays 3; owner drops req[3] with req=0 -> IDLE next cycle, gnt=0.
- Sole requester 6 keeps req high and pulses done -> gnt=0 for exactly one cycle, then gnt_idx=6 again.
- Macro on, req=8'b0001_0001, no done -> owner 0 held 4 cycles, then timeout=1 for one cycle with gnt_idx=4 on the same cycle. Owner 4 is likewise force-released after 4 cycles, and grant returns to 0.
- Assert reset=0 asynchronously mid-grant, between clock edges -> gnt, gnt_idx, gnt_valid and timeout clear immediately. After release, req=8'hFF -> first grant is index 0.
